// File: rtl/cmp_pkg.sv
// Shared types for the comparator result tracker: FSM states, result classes and flag decode.
// Multi-hot handling of the decode depends on CMP_ONEHOT_CHECK_EN.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED,
    FLUSH
  } state_t;

  typedef logic [2:0] cls_t;

  localparam cls_t EQ      = 3'd0;
  localparam cls_t GT      = 3'd1;
  localparam cls_t LT      = 3'd2;
  localparam cls_t NONE    = 3'd3;
  localparam cls_t ILLEGAL = 3'd4;

  // code is {S1, S2, S3} = {equal, greater, less}
  function automatic cls_t cmp_decode(input logic [2:0] code);
    cls_t cls;
    cls = NONE;
    case (code)
      3'b100:  cls = EQ;
      3'b010:  cls = GT;
      3'b001:  cls = LT;
      3'b000:  cls = NONE;
      default: begin
`ifdef CMP_ONEHOT_CHECK_EN
        cls = ILLEGAL;
`else
        // Multi-hot falls back to comparator priority S1 > S2 > S3
        cls = code[2] ? EQ : GT;
`endif
      end
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cmp_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module cmp_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cmp_result_tracker.sv
// Tracks comparator results: saturating per-class counts, equal-run length and a lock flag.
// Define CMP_ONEHOT_CHECK_EN to flag non-one-hot codes on the sticky err output.
module cmp_result_tracker
  import cmp_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RUN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             S1,
  input  logic             S2,
  input  logic             S3,
  input  logic             clear,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] run_cnt,
  output logic             lock
`ifdef CMP_ONEHOT_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);

  state_t           state_q, state_d;
  logic             lock_q;
  cls_t             cls;
  logic             take;
  logic             run_clr;
  logic [CNT_W-1:0] run_inc;

  assign in_ready = (state_q != FLUSH);
  assign cls      = cmp_decode({S1, S2, S3});
  // clear wins over a same-cycle accept, so the sample is dropped
  assign take     = in_valid && in_ready && !clear;
  assign run_clr  = clear || (take && (cls == GT || cls == LT || cls == ILLEGAL));
  assign run_inc  = (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;

  cmp_sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
    .clk(clk), .rst(rst), .clr_i(clear), .inc_i(take && cls == EQ), .cnt_o(eq_cnt)
  );
  cmp_sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
    .clk(clk), .rst(rst), .clr_i(clear), .inc_i(take && cls == GT), .cnt_o(gt_cnt)
  );
  cmp_sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
    .clk(clk), .rst(rst), .clr_i(clear), .inc_i(take && cls == LT), .cnt_o(lt_cnt)
  );
  cmp_sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
    .clk(clk), .rst(rst), .clr_i(run_clr), .inc_i(take && cls == EQ), .cnt_o(run_cnt)
  );

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = FLUSH;
    end else if (state_q == FLUSH) begin
      state_d = IDLE;
    end else if (take) begin
      case (cls)
        EQ:          state_d = (run_inc >= RUN_LEN_C) ? LOCKED : TRACK;
        GT, LT:      state_d = TRACK;
        ILLEGAL:     state_d = TRACK;
        default:     state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= (state_d == LOCKED);
    end
  end

  assign lock = lock_q;

`ifdef CMP_ONEHOT_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_q <= 1'b0;
    end else if (take && (cls == ILLEGAL || cls == NONE)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Directed bench for cmp_result_tracker: 8-bit instance for function, 4-bit instance for saturation.
module tb_cmp_result_tracker;

  logic clk = 1'b0;
  logic rst, in_valid, S1, S2, S3, clear;

  logic       in_ready, lock;
  logic [7:0] eq_cnt, gt_cnt, lt_cnt, run_cnt;
  logic       rdy4, lock4;
  logic [3:0] eq4, gt4, lt4, run4;
`ifdef CMP_ONEHOT_CHECK_EN
  logic err, err4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cmp_result_tracker #(.CNT_W(8), .RUN_LEN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .S1(S1), .S2(S2), .S3(S3), .clear(clear),
    .eq_cnt(eq_cnt), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .run_cnt(run_cnt),
    .lock(lock)
`ifdef CMP_ONEHOT_CHECK_EN
    , .err(err)
`endif
  );

  cmp_result_tracker #(.CNT_W(4), .RUN_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
    .S1(S1), .S2(S2), .S3(S3), .clear(clear),
    .eq_cnt(eq4), .gt_cnt(gt4), .lt_cnt(lt4), .run_cnt(run4),
    .lock(lock4)
`ifdef CMP_ONEHOT_CHECK_EN
    , .err(err4)
`endif
  );

  // Apply one cycle of stimulus; outputs are read 1ns after the edge.
  task automatic drive(input logic v, input logic [2:0] code, input logic c);
    in_valid = v;
    {S1, S2, S3} = code;
    clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 3'b000, 1'b0);
    drive(1'b0, 3'b000, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (eq_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_eq: got %0d want 0", eq_cnt); end
    n_tests++; if (gt_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_gt: got %0d want 0", gt_cnt); end
    n_tests++; if (lt_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_lt: got %0d want 0", lt_cnt); end
    n_tests++; if (run_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_run: got %0d want 0", run_cnt); end
    n_tests++; if (lock !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b want 0", lock); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
`ifdef CMP_ONEHOT_CHECK_EN
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
`endif
  endtask

  task automatic test_eq_lock();
    for (int i = 0; i < 3; i++) drive(1'b1, 3'b100, 1'b0);
    n_tests++; if (eq_cnt !== 8'd3) begin n_fail++; $display("FAIL eq3_eq: got %0d want 3", eq_cnt); end
    n_tests++; if (run_cnt !== 8'd3) begin n_fail++; $display("FAIL eq3_run: got %0d want 3", run_cnt); end
    n_tests++; if (lock !== 1'b0) begin n_fail++; $display("FAIL eq3_lock: got %b want 0", lock); end
    drive(1'b1, 3'b100, 1'b0);
    n_tests++; if (eq_cnt !== 8'd4) begin n_fail++; $display("FAIL eq4_eq: got %0d want 4", eq_cnt); end
    n_tests++; if (run_cnt !== 8'd4) begin n_fail++; $display("FAIL eq4_run: got %0d want 4", run_cnt); end
    n_tests++; if (lock !== 1'b1) begin n_fail++; $display("FAIL eq4_lock: got %b want 1", lock); end
  endtask

  task automatic test_gt_unlock();
    drive(1'b1, 3'b010, 1'b0);
    n_tests++; if (gt_cnt !== 8'd1) begin n_fail++; $display("FAIL gt_cnt: got %0d want 1", gt_cnt); end
    n_tests++; if (run_cnt !== 8'd0) begin n_fail++; $display("FAIL gt_run: got %0d want 0", run_cnt); end
    n_tests++; if (lock !== 1'b0) begin n_fail++; $display("FAIL gt_lock: got %b want 0", lock); end
    n_tests++; if (eq_cnt !== 8'd4) begin n_fail++; $display("FAIL gt_eq_hold: got %0d want 4", eq_cnt); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'b001, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 3'b100, 1'b0);
    n_tests++; if (lt_cnt !== 8'd1) begin n_fail++; $display("FAIL b2b_lt: got %0d want 1", lt_cnt); end
    n_tests++; if (run_cnt !== 8'd3) begin n_fail++; $display("FAIL b2b_run3: got %0d want 3", run_cnt); end
    n_tests++; if (lock !== 1'b0) begin n_fail++; $display("FAIL b2b_lock3: got %b want 0", lock); end
    drive(1'b1, 3'b100, 1'b0);
    n_tests++; if (eq_cnt !== 8'd8) begin n_fail++; $display("FAIL b2b_eq: got %0d want 8", eq_cnt); end
    n_tests++; if (lock !== 1'b1) begin n_fail++; $display("FAIL b2b_lock4: got %b want 1", lock); end
  endtask

  task automatic test_idle_inputs();
    drive(1'b0, 3'b010, 1'b0);
    n_tests++; if (gt_cnt !== 8'd1) begin n_fail++; $display("FAIL novalid_gt: got %0d want 1", gt_cnt); end
    n_tests++; if (lock !== 1'b1) begin n_fail++; $display("FAIL novalid_lock: got %b want 1", lock); end
    drive(1'b1, 3'b000, 1'b0);
    n_tests++; if ({eq_cnt, gt_cnt, lt_cnt} !== {8'd8, 8'd1, 8'd1}) begin
      n_fail++; $display("FAIL zerohot_cnts: got %0d/%0d/%0d want 8/1/1", eq_cnt, gt_cnt, lt_cnt);
    end
    n_tests++; if (run_cnt !== 8'd4) begin n_fail++; $display("FAIL zerohot_run: got %0d want 4", run_cnt); end
`ifdef CMP_ONEHOT_CHECK_EN
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL zerohot_err: got %b want 1", err); end
`endif
  endtask

  task automatic test_clear();
    drive(1'b1, 3'b100, 1'b1);
    n_tests++; if ({eq_cnt, gt_cnt, lt_cnt, run_cnt} !== 32'd0) begin
      n_fail++; $display("FAIL clear_cnts: got %0d/%0d/%0d/%0d want 0/0/0/0", eq_cnt, gt_cnt, lt_cnt, run_cnt);
    end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready_flush: got %b want 0", in_ready); end
    n_tests++; if (lock !== 1'b0) begin n_fail++; $display("FAIL clear_lock: got %b want 0", lock); end
`ifdef CMP_ONEHOT_CHECK_EN
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL clear_err: got %b want 0", err); end
`endif
    drive(1'b1, 3'b100, 1'b0);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clear_ready_idle: got %b want 1", in_ready); end
    n_tests++; if (eq_cnt !== 8'd0) begin n_fail++; $display("FAIL clear_eq_flush: got %0d want 0", eq_cnt); end
  endtask

  task automatic test_multihot();
    drive(1'b1, 3'b110, 1'b0);
`ifdef CMP_ONEHOT_CHECK_EN
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL multihot_err: got %b want 1", err); end
    n_tests++; if (eq_cnt !== 8'd0) begin n_fail++; $display("FAIL multihot_eq: got %0d want 0", eq_cnt); end
    n_tests++; if (run_cnt !== 8'd0) begin n_fail++; $display("FAIL multihot_run: got %0d want 0", run_cnt); end
`else
    n_tests++; if (eq_cnt !== 8'd1) begin n_fail++; $display("FAIL multihot_eq: got %0d want 1", eq_cnt); end
    n_tests++; if (run_cnt !== 8'd1) begin n_fail++; $display("FAIL multihot_run: got %0d want 1", run_cnt); end
    drive(1'b1, 3'b011, 1'b0);
    n_tests++; if (gt_cnt !== 8'd1) begin n_fail++; $display("FAIL multihot_gt: got %0d want 1", gt_cnt); end
    n_tests++; if (lt_cnt !== 8'd0) begin n_fail++; $display("FAIL multihot_lt: got %0d want 0", lt_cnt); end
`endif
    n_tests++; if (gt_cnt + lt_cnt === 8'd0) begin
`ifndef CMP_ONEHOT_CHECK_EN
      n_fail++; $display("FAIL multihot_class: got gt+lt %0d want 1", gt_cnt + lt_cnt);
`endif
    end
  endtask

  task automatic test_rst_locked();
    for (int i = 0; i < 4; i++) drive(1'b1, 3'b100, 1'b0);
    n_tests++; if (lock !== 1'b1) begin n_fail++; $display("FAIL pre_rst_lock: got %b want 1", lock); end
    rst = 1'b1;
    drive(1'b1, 3'b100, 1'b1);
    rst = 1'b0;
    n_tests++; if ({eq_cnt, gt_cnt, lt_cnt, run_cnt} !== 32'd0) begin
      n_fail++; $display("FAIL rst_cnts: got %0d/%0d/%0d/%0d want 0/0/0/0", eq_cnt, gt_cnt, lt_cnt, run_cnt);
    end
    n_tests++; if (lock !== 1'b0) begin n_fail++; $display("FAIL rst_lock: got %b want 0", lock); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    drive(1'b0, 3'b000, 1'b0);
    n_tests++; if (eq_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_sample_dropped: got %0d want 0", eq_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 3'b001, 1'b0);
    n_tests++; if (lt4 !== 4'd15) begin n_fail++; $display("FAIL sat_lt4: got %0d want 15", lt4); end
    n_tests++; if (lt_cnt !== 8'd20) begin n_fail++; $display("FAIL sat_lt8: got %0d want 20", lt_cnt); end
    for (int i = 0; i < 20; i++) drive(1'b1, 3'b100, 1'b0);
    n_tests++; if (run4 !== 4'd15) begin n_fail++; $display("FAIL sat_run4: got %0d want 15", run4); end
    n_tests++; if (eq4 !== 4'd15) begin n_fail++; $display("FAIL sat_eq4: got %0d want 15", eq4); end
    n_tests++; if (lock4 !== 1'b1) begin n_fail++; $display("FAIL sat_lock4: got %b want 1", lock4); end
    n_tests++; if (run_cnt !== 8'd20) begin n_fail++; $display("FAIL sat_run8: got %0d want 20", run_cnt); end
    drive(1'b1, 3'b010, 1'b0);
    n_tests++; if ({run4, lock4, gt4} !== {4'd0, 1'b0, 4'd1}) begin
      n_fail++; $display("FAIL sat_unlock4: got run=%0d lock=%b gt=%0d want 0/0/1", run4, lock4, gt4);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; S1 = 1'b0; S2 = 1'b0; S3 = 1'b0; clear = 1'b0;
    test_reset();
    test_eq_lock();
    test_gt_unlock();
    test_back_to_back();
    test_idle_inputs();
    test_clear();
    test_multihot();
    test_rst_locked();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_result_tracker.md
# cmp_result_tracker

- Downstream stage of the 4-bit magnitude comparator.
- Consumes its one-hot result flags (S1 = A==B, S2 = A>B, S3 = A<B) through a valid/ready handshake.
- Keeps saturating per-class counts and a run length of consecutive equal results.
- Raises a lock flag once the equal-run reaches a programmable length, for use as a "match stable" indication by the control logic above it.

## Interface
- CNT_W, 8: width of each class counter and of the run counter.
- RUN_LEN, 4: consecutive equal results required to assert lock; legal range 1 to 2^CNT_W-1.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  a comparator result is presented on S1/S2/S3.
- in_ready  output  1  tracker can accept a result this cycle.
- S1  input  1  equal flag from comparator.
- S2  input  1  greater-than flag from comparator.
- S3  input  1  less-than flag from comparator.
- clear  input  1  single-cycle request to zero all statistics.
- eq_cnt  output  CNT_W  accepted equal results, saturating.
- gt_cnt  output  CNT_W  accepted greater results, saturating.
- lt_cnt  output  CNT_W  accepted less results, saturating.
- run_cnt  output  CNT_W  current consecutive-equal run, saturating.
- lock  output  1  run_cnt >= RUN_LEN.
- err  output  1  sticky illegal-code flag; present only with CMP_ONEHOT_CHECK_EN.

## Operation
- Accept = in_valid && in_ready.
- States:
  - IDLE: post reset/clear, no result accepted yet.
  - TRACK: normal counting.
  - LOCKED: lock held.
  - FLUSH: one-cycle zeroing after clear.
- in_ready = 1 in IDLE, TRACK and LOCKED; 0 in FLUSH.
- IDLE → TRACK on first accept, or → LOCKED if RUN_LEN==1 and the result is equal.
- On accept of an equal result:
  - eq_cnt+1 and run_cnt+1, both saturating at 2^CNT_W-1.
  - Entering run_cnt == RUN_LEN moves TRACK → LOCKED.
- On accept of a greater or less result:
  - gt_cnt or lt_cnt +1, saturating.
  - run_cnt ← 0.
  - LOCKED → TRACK.
- clear in any state → FLUSH next cycle, with all counters, run_cnt and err zeroed. FLUSH → IDLE unconditionally.
- clear together with an accept: clear wins, and the sample is dropped and not counted.
- Zero-hot code on accept (none of S1/S2/S3 set): ignored, with no counter or run change.
- Multi-hot handling depends on the macro (see Configuration).

## Timing
- Reset values: all counters 0, run_cnt 0, lock 0, err 0, state IDLE, hence in_ready 1 on the first cycle after reset.
- rst mid-operation overrides clear and any accept that cycle.
- Latency: counters, run_cnt and lock are registered and reflect an accepted result one cycle after the accepting edge.
- Back-to-back accepts every cycle are supported, except the single FLUSH cycle.
- lock is a registered decode of state (LOCKED). It deasserts on the edge that accepts a non-equal result.
- A saturated run_cnt keeps lock asserted and does not wrap.
- in_ready is a combinational decode of state only. It never depends on in_valid.

## Configuration
- Macro CMP_ONEHOT_CHECK_EN.
- Defined:
  - A multi-hot code on accept sets sticky err.
  - The code is not counted in any class and resets run_cnt.
  - LOCKED → TRACK.
  - A zero-hot code also sets err.
  - err clears only on rst or clear.
- Undefined:
  - err port absent.
  - Multi-hot codes decode by priority S1 > S2 > S3, matching comparator priority.
  - Zero-hot codes are silently ignored.

## Structure
- Shared package cmp_pkg holds:
  - state typedef (IDLE, TRACK, LOCKED, FLUSH);
  - result-class localparams EQ/GT/LT/NONE/ILLEGAL;
  - the decode function from {S1,S2,S3} to class.
- One sub-module, cmp_sat_counter: parameterised CNT_W, with inc/clr inputs and a saturating count, instantiated four times (eq, gt, lt, run).

## Test plan
- Reset, then 3 equal results back-to-back with RUN_LEN=4 → eq_cnt=3, run_cnt=3, lock=0; fourth equal → lock=1 one cycle later.
- In LOCKED, feed S2=1 → gt_cnt+1, run_cnt=0, lock=0 on the next cycle.
- CNT_W=4, 20 consecutive S3 results → lt_cnt holds at 15, no wrap.
- Assert clear with in_valid and S1 in the same cycle → next cycle all counters 0 and in_ready=0; the cycle after → in_ready=1, eq_cnt still 0.
- With CMP_ONEHOT_CHECK_EN, S1=S2=1 accepted → err=1, no counter change, run_cnt=0. Without it → eq_cnt+1.
- Assert rst while LOCKED with in_valid high → all outputs 0, state IDLE, sample not counted.
